instruction_decoder: RTL and testbench

Decode stage directly downstream of the 3-state fetch state machine. Captures each fetched 32-bit instruction and its PC into a small buffer, and decodes the buffer head into register addresses, immediate and control strobes. Issues the decoded instruction to the register bank / ALU with a valid/ready handshake. Fetch cannot stall, so a buffer overrun is flagged rather than back-pressured.

---
 rtl/instruction_decoder_pkg.sv | 62 ++++++
 rtl/instruction_decoder_if.sv | 33 +++
 rtl/instruction_decoder_decode_fifo.sv | 73 +++++++
 rtl/instruction_decoder.sv | 152 +++++++++++++++
 tb/tb_instruction_decoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_decoder_pkg.sv
// rtl/instruction_decoder_pkg.sv - shared encodings for the decode stage
// Purpose: fetch-state encodings, opcode and ALU function codes, instruction
// field positions and the buffer entry / control-strobe record types.
package instruction_decoder_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } fetch_state_e;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRL  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h09;
  localparam logic [5:0] OP_SW   = 6'h0A;
  localparam logic [5:0] OP_BEQ  = 6'h0B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RD_HI     = 25;
  localparam int RD_LO     = 21;
  localparam int RS_HI     = 20;
  localparam int RS_LO     = 16;
  localparam int RT_HI     = 15;
  localparam int RT_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  localparam int ENTRY_W = 48;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
  } entry_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/instruction_decoder_if.sv
// rtl/instruction_decoder_if.sv - issue bus between decode and register bank / ALU
// Purpose: valid/ready issue handshake plus the decoded head instruction.
// master: decode stage (drives everything except issue_ready)
// slave : consumer (drives issue_ready)
interface instruction_decoder_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [3:0]  alu_op;
  logic        use_imm;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;
  logic [15:0] instr_pc;

  modport master (
    output issue_valid, opcode, rd, rs, rt, imm, alu_op, use_imm,
           reg_write, mem_read, mem_write, branch, illegal, instr_pc,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, opcode, rd, rs, rt, imm, alu_op, use_imm,
           reg_write, mem_read, mem_write, branch, illegal, instr_pc,
    output issue_ready
  );
endinterface

// File: rtl/instruction_decoder_decode_fifo.sv
// rtl/instruction_decoder_decode_fifo.sv - small synchronous FIFO holding fetched entries
// Purpose: DEPTH-entry FIFO with flush and simultaneous push/pop.
// Ports: clk, reset (async active-low), flush (clears contents), push/wdata,
//        pop, rdata (head, combinational), full, empty.
module decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves on the same edge.
    do_push  = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - decode stage behind the 3-state fetch machine
// Purpose: captures each fetched instruction with its PC, decodes the buffer
// head and issues it over a valid/ready handshake.
// Ports: clk, reset (async active-low); instruction_in, fetch_state, pc_in from
//        fetch; issue (master modport: handshake + decoded fields/strobes);
//        halted, overflow (sticky dropped capture), instr_count (completed issues).
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instruction_in,
  input  logic [1:0]             fetch_state,
  input  logic [15:0]            pc_in,
  instruction_decoder_if.master  issue,
  output logic                   halted,
  output logic                   overflow,
  output logic [CNT_W-1:0]       instr_count
);

  logic [1:0]       fetch_state_q, fetch_state_d;
  logic             halted_q, halted_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  entry_t           head;
  entry_t           new_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic             full;
  logic             empty;
  logic             valid;
  logic             capture;
  logic             take;
  logic             push;
  logic             pop;
  logic             flush;
  logic [5:0]       head_op;
  ctrl_t            ctrl;

  // The fetch machine leaves S2 for S0 exactly once per instruction; that
  // transition is the only point where instruction_in is guaranteed stable.
  assign capture = (fetch_state == S0) && (fetch_state_q == S2);

  assign valid   = !empty && !halted_q;
  assign pop     = valid && issue.issue_ready;
  assign head_op = head.instr[OPCODE_HI:OPCODE_LO];
  // A retiring HALT empties the buffer, including anything pushed the same edge.
  assign flush   = pop && (head_op == OP_HALT);
  assign take    = capture && !halted_q && !flush;
  assign push    = take && (!full || pop);

  // pc_in has already been incremented by fetch; store the instruction's own address.
  assign new_entry.instr = instruction_in;
  assign new_entry.pc    = pc_in - 16'd1;
  assign head            = entry_t'(head_raw);

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (new_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    ctrl = '0;
    case (head_op)
      OP_NOP:  ;
      OP_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; end
      OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_write = 1'b1; end
      OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_write = 1'b1; end
      OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_write = 1'b1; end
      OP_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_write = 1'b1; end
      OP_SLL:  begin ctrl.alu_op = ALU_SLL; ctrl.reg_write = 1'b1; end
      OP_SRL:  begin ctrl.alu_op = ALU_SRL; ctrl.reg_write = 1'b1; end
      OP_ADDI: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.use_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.use_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.use_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ:  begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1; end
      OP_HALT: ;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // Everything is forced to zero while nothing is offered, so idle outputs are stable.
  assign issue.issue_valid = valid;
  assign issue.opcode      = valid ? head_op : '0;
  assign issue.rd          = valid ? head.instr[RD_HI:RD_LO] : '0;
  assign issue.rs          = valid ? head.instr[RS_HI:RS_LO] : '0;
  assign issue.rt          = valid ? head.instr[RT_HI:RT_LO] : '0;
  assign issue.imm         = valid ? head.instr[IMM_HI:IMM_LO] : '0;
  assign issue.instr_pc    = valid ? head.pc : '0;
  assign issue.alu_op      = valid ? ctrl.alu_op : '0;
  assign issue.use_imm     = valid && ctrl.use_imm;
  assign issue.reg_write   = valid && ctrl.reg_write;
  assign issue.mem_read    = valid && ctrl.mem_read;
  assign issue.mem_write   = valid && ctrl.mem_write;
  assign issue.branch      = valid && ctrl.branch;
  assign issue.illegal     = valid && ctrl.illegal;

  always_comb begin
    fetch_state_d = fetch_state;
    halted_d      = halted_q | flush;
    overflow_d    = overflow_q | (take && full && !pop);
    instr_count_d = instr_count_q;
    if (pop) begin
      instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_state_q <= S0;
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      fetch_state_q <= fetch_state_d;
      halted_q      <= halted_d;
      overflow_q    <= overflow_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign halted      = halted_q;
  assign overflow    = overflow_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - self-checking bench for instruction_decoder
module tb_instruction_decoder;
  import instruction_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction_in = '0;
  logic [1:0]  fetch_state = 2'b00;
  logic [15:0] pc_in = '0;
  logic        halted;
  logic        overflow;
  logic [15:0] instr_count;

  instruction_decoder_if issue_if ();

  instruction_decoder #(
    .DEPTH (2),
    .CNT_W (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_in (instruction_in),
    .fetch_state    (fetch_state),
    .pc_in          (pc_in),
    .issue          (issue_if),
    .halted         (halted),
    .overflow       (overflow),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [3:0]  alu;
    logic [5:0]  flags;   // use_imm, reg_write, mem_read, mem_write, branch, illegal
    logic [4:0]  rt;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        tbl [16];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_count;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {issue_if.use_imm, issue_if.reg_write, issue_if.mem_read,
            issue_if.mem_write, issue_if.branch, issue_if.illegal};
  endfunction

  // One full S1 -> S2 -> S0 fetch; returns at the falling edge after the capture edge.
  task automatic fetch(input logic [31:0] ins, input logic [15:0] pc,
                       input logic rdy_pre, input logic rdy_cap);
    @(negedge clk);
    fetch_state = 2'b01;
    issue_if.issue_ready = rdy_pre;
    @(negedge clk);
    fetch_state = 2'b10;
    instruction_in = ins;
    pc_in = pc;
    @(negedge clk);
    fetch_state = 2'b00;
    issue_if.issue_ready = rdy_cap;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{6'h01, 5'd1,  5'd2,  16'h1800, 16'h0001, 4'd0, 6'b010000, 5'h03, 16'h0000};
    tbl[1]  = '{6'h00, 5'd0,  5'd0,  16'h0000, 16'h0010, 4'd0, 6'b000000, 5'h00, 16'h000F};
    tbl[2]  = '{6'h02, 5'd31, 5'd0,  16'hF8A5, 16'h0000, 4'd1, 6'b010000, 5'h1F, 16'hFFFF};
    tbl[3]  = '{6'h03, 5'd7,  5'd8,  16'h8001, 16'h1234, 4'd2, 6'b010000, 5'h10, 16'h1233};
    tbl[4]  = '{6'h04, 5'd9,  5'd10, 16'h0800, 16'h0100, 4'd3, 6'b010000, 5'h01, 16'h00FF};
    tbl[5]  = '{6'h05, 5'd3,  5'd3,  16'h0000, 16'h0002, 4'd4, 6'b010000, 5'h00, 16'h0001};
    tbl[6]  = '{6'h06, 5'd5,  5'd6,  16'h1800, 16'h0003, 4'd5, 6'b010000, 5'h03, 16'h0002};
    tbl[7]  = '{6'h07, 5'd0,  5'd1,  16'h0800, 16'h0004, 4'd6, 6'b010000, 5'h01, 16'h0003};
    tbl[8]  = '{6'h08, 5'd4,  5'd5,  16'h0123, 16'h0005, 4'd0, 6'b110000, 5'h00, 16'h0004};
    tbl[9]  = '{6'h09, 5'd6,  5'd7,  16'hFFFC, 16'h0006, 4'd0, 6'b111000, 5'h1F, 16'h0005};
    tbl[10] = '{6'h0A, 5'd8,  5'd9,  16'h0010, 16'h0007, 4'd0, 6'b100100, 5'h00, 16'h0006};
    tbl[11] = '{6'h0B, 5'd1,  5'd2,  16'hFFFE, 16'h0008, 4'd1, 6'b000010, 5'h1F, 16'h0007};
    tbl[12] = '{6'h20, 5'd1,  5'd1,  16'h0001, 16'h0009, 4'd0, 6'b000001, 5'h00, 16'h0008};
    tbl[13] = '{6'h00, 5'd2,  5'd2,  16'h0000, 16'h000A, 4'd0, 6'b000000, 5'h00, 16'h0009};
    tbl[14] = '{6'h3E, 5'd0,  5'd0,  16'h0000, 16'h000B, 4'd0, 6'b000001, 5'h00, 16'h000A};
    tbl[15] = '{6'h0C, 5'd0,  5'd0,  16'h0000, 16'hFFFF, 4'd0, 6'b000001, 5'h00, 16'hFFFE};

    issue_if.issue_ready = 1'b0;
    exp_count = 16'd0;

    // Reset state
    #2;
    chk("rst_valid", {47'd0, issue_if.issue_valid}, 48'd0);
    chk("rst_flags", {42'd0, flags_now()}, 48'd0);
    chk("rst_pc", {32'd0, issue_if.instr_pc}, 48'd0);
    chk("rst_status", {30'd0, halted, overflow, instr_count}, 48'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table: one instruction per fetch, checked while held, then issued
    for (int i = 0; i < 16; i++) begin
      fetch({tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm}, tbl[i].pc, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", i), {47'd0, issue_if.issue_valid}, 48'd1);
      chk($sformatf("v%0d_opcode", i), {42'd0, issue_if.opcode}, {42'd0, tbl[i].op});
      chk($sformatf("v%0d_regs", i), {33'd0, issue_if.rd, issue_if.rs, issue_if.rt},
          {33'd0, tbl[i].rd, tbl[i].rs, tbl[i].rt});
      chk($sformatf("v%0d_imm", i), {32'd0, issue_if.imm}, {32'd0, tbl[i].imm});
      chk($sformatf("v%0d_alu", i), {44'd0, issue_if.alu_op}, {44'd0, tbl[i].alu});
      chk($sformatf("v%0d_flags", i), {42'd0, flags_now()}, {42'd0, tbl[i].flags});
      chk($sformatf("v%0d_pc", i), {32'd0, issue_if.instr_pc}, {32'd0, tbl[i].exp_pc});
      issue_if.issue_ready = 1'b1;
      step();
      issue_if.issue_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      chk($sformatf("v%0d_popped", i), {47'd0, issue_if.issue_valid}, 48'd0);
      chk($sformatf("v%0d_count", i), {32'd0, instr_count}, {32'd0, exp_count});
    end

    // Full buffer with a pop on the capture edge: push accepted, order kept
    fetch(32'h0422_1800, 16'h0040, 1'b0, 1'b0);   // ADD @3F
    fetch(32'h0800_0000, 16'h0041, 1'b0, 1'b0);   // SUB @40
    chk("full_head", {32'd0, issue_if.instr_pc}, 48'h3F);
    fetch(32'h1400_0000, 16'h0042, 1'b0, 1'b1);   // XOR @41, ready on capture edge
    exp_count = exp_count + 16'd1;
    chk("fullpop_head_pc", {32'd0, issue_if.instr_pc}, 48'h40);
    chk("fullpop_head_op", {42'd0, issue_if.opcode}, 48'h02);
    chk("fullpop_ovf", {47'd0, overflow}, 48'd0);
    step();
    exp_count = exp_count + 16'd1;
    chk("fullpop_third_pc", {32'd0, issue_if.instr_pc}, 48'h41);
    chk("fullpop_third_op", {42'd0, issue_if.opcode}, 48'h05);
    step();
    issue_if.issue_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk("fullpop_empty", {47'd0, issue_if.issue_valid}, 48'd0);
    chk("fullpop_count", {32'd0, instr_count}, {32'd0, exp_count});

    // Asynchronous reset in the middle of a stalled handshake
    fetch(32'h0422_1800, 16'h0060, 1'b0, 1'b0);
    fetch(32'h0800_0000, 16'h0061, 1'b0, 1'b0);
    chk("pre_rst_valid", {47'd0, issue_if.issue_valid}, 48'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {47'd0, issue_if.issue_valid}, 48'd0);
    chk("async_rst_op", {42'd0, issue_if.opcode}, 48'd0);
    chk("async_rst_flags", {42'd0, flags_now()}, 48'd0);
    chk("async_rst_pc", {32'd0, issue_if.instr_pc}, 48'd0);
    chk("async_rst_count", {32'd0, instr_count}, 48'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_count = 16'd0;
    fetch(32'h0422_1800, 16'h0070, 1'b1, 1'b1);
    chk("post_rst_valid", {47'd0, issue_if.issue_valid}, 48'd1);
    chk("post_rst_pc", {32'd0, issue_if.instr_pc}, 48'h6F);
    chk("post_rst_count0", {32'd0, instr_count}, 48'd0);
    step();
    exp_count = exp_count + 16'd1;
    chk("post_rst_count1", {32'd0, instr_count}, {32'd0, exp_count});

    // fetch_state 11 never causes a capture
    @(negedge clk); fetch_state = 2'b01;
    @(negedge clk); fetch_state = 2'b10; instruction_in = 32'h0422_1800; pc_in = 16'h0090;
    @(negedge clk); fetch_state = 2'b11;
    @(negedge clk); fetch_state = 2'b00;
    step();
    chk("fs11_no_capture", {47'd0, issue_if.issue_valid}, 48'd0);
    step();
    chk("fs11_count", {32'd0, instr_count}, {32'd0, exp_count});

    // HALT retires, later fetches are ignored without overflow
    fetch(32'hFC00_0000, 16'h0051, 1'b0, 1'b0);
    chk("halt_valid", {47'd0, issue_if.issue_valid}, 48'd1);
    chk("halt_op", {42'd0, issue_if.opcode}, 48'h3F);
    chk("halt_flags", {42'd0, flags_now()}, 48'd0);
    issue_if.issue_ready = 1'b1;
    step();
    exp_count = exp_count + 16'd1;
    chk("halted", {47'd0, halted}, 48'd1);
    chk("halted_valid", {47'd0, issue_if.issue_valid}, 48'd0);
    for (int k = 0; k < 3; k++) begin
      fetch(32'h0422_1800, 16'h0052 + 16'(k), 1'b1, 1'b1);
      chk($sformatf("halt_ignore%0d", k), {47'd0, issue_if.issue_valid}, 48'd0);
    end
    chk("halt_no_ovf", {47'd0, overflow}, 48'd0);
    chk("halt_count", {32'd0, instr_count}, {32'd0, exp_count});
    issue_if.issue_ready = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 16'd0;
    chk("halt_cleared", {47'd0, halted}, 48'd0);

    // Overflow: stalled consumer, three fetches into a two-entry buffer
    fetch(32'h2085_0123, 16'h0080, 1'b0, 1'b0);   // ADDI @7F
    chk("ovf_h1_pc", {32'd0, issue_if.instr_pc}, 48'h7F);
    fetch(32'h24C7_FFFC, 16'h0081, 1'b0, 1'b0);   // LW @80
    chk("ovf_hold_pc", {32'd0, issue_if.instr_pc}, 48'h7F);
    chk("ovf_hold_op", {42'd0, issue_if.opcode}, 48'h08);
    chk("ovf_not_yet", {47'd0, overflow}, 48'd0);
    fetch(32'h2909_0010, 16'h0082, 1'b0, 1'b0);   // SW @81, dropped
    chk("ovf_set", {47'd0, overflow}, 48'd1);
    chk("ovf_head_pc", {32'd0, issue_if.instr_pc}, 48'h7F);
    issue_if.issue_ready = 1'b1;
    step();
    chk("ovf_second_op", {42'd0, issue_if.opcode}, 48'h09);
    chk("ovf_second_pc", {32'd0, issue_if.instr_pc}, 48'h80);
    chk("ovf_second_flags", {42'd0, flags_now()}, 48'b111000);
    step();
    issue_if.issue_ready = 1'b0;
    chk("ovf_drained", {47'd0, issue_if.issue_valid}, 48'd0);
    chk("ovf_count", {32'd0, instr_count}, 48'd2);
    step();
    chk("ovf_sticky", {47'd0, overflow}, 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
